// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid bus; the fetch unit is the master.
interface if_fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/if_fetch_unit_pc_next_sel.sv
// Next-PC mux: redirect target > sequential advance > hold.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_pc_next
);

    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_plus;

    // Redirect targets are always word aligned.
    assign w_target  = i_redirect_pc & ({ADDR_W{1'b1}} << 2);
    assign w_pc_plus = i_pc + ADDR_W'(INSTR_BYTES);

    always_comb begin
        o_pc_next = i_pc;
        if (i_redirect) begin
            o_pc_next = w_target;
        end else if (i_advance) begin
            o_pc_next = w_pc_plus;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem request, presents {instr, pc, pc+4} to IF/ID.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    if_fetch_unit_if.master   imem,
    output logic              fetch_valid_o,
    output logic [31:0]       fetch_instr_o,
    output logic [ADDR_W-1:0] fetch_pc_o,
    output logic [ADDR_W-1:0] fetch_pcplus4_o
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [31:0]       r_instr;
    logic              w_instr_load;
    logic              w_advance;

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_sel (
        .i_pc          (r_pc),
        .i_redirect    (redirect_i),
        .i_redirect_pc (redirect_pc_i),
        .i_advance     (w_advance),
        .o_pc_next     (w_pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= REQ;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_instr_load) begin
                r_instr <= imem.rdata;
            end
        end
    end

    // A redirect reloads the PC in every state; only the state transition differs.
    always_comb begin
        w_state_next = r_state;
        w_instr_load = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            REQ: begin
                if (imem.gnt) begin
                    w_state_next = redirect_i ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem.rvalid) begin
                    if (redirect_i) begin
                        w_state_next = REQ;
                    end else begin
                        w_instr_load = 1'b1;
                        w_state_next = HOLD;
                    end
                end else if (redirect_i) begin
                    w_state_next = DROP;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    w_state_next = REQ;
                end else if (!stall_i) begin
                    w_advance    = 1'b1;
                    w_state_next = REQ;
                end
            end
            DROP: begin
                if (imem.rvalid) begin
                    w_state_next = REQ;
                end
            end
            default: w_state_next = REQ;
        endcase
    end

    assign imem.req        = (r_state == REQ);
    assign imem.addr       = r_pc;
    assign fetch_valid_o   = (r_state == HOLD);
    assign fetch_instr_o   = r_instr;
    assign fetch_pc_o      = r_pc;
    assign fetch_pcplus4_o = r_pc + ADDR_W'(INSTR_BYTES);

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues requests to instruction memory over a req/gnt/rvalid handshake, with one request outstanding at a time. It buffers the returned word and presents {instr, PC, PC+4} with a valid flag to IF/ID. It honours stall from hazard control and redirects (branch/jump) from later stages. The IF/ID register writes when fetch_valid_o && !stall_i; it is cleared when fetch_valid_o is low.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ADDR_W, 32, PC and memory address width; fixed at 32 for this core.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
stall_i  input  1  downstream cannot accept; hold the current instruction.
redirect_i  input  1  control-flow change; discard in-flight and held fetches.
redirect_pc_i  input  32  new fetch target; bits [1:0] are forced to 0.
imem_req_o  output  1  fetch request.
imem_addr_o  output  32  fetch address; equals pc_q.
imem_gnt_i  input  1  memory accepted the request this cycle.
imem_rvalid_i  input  1  read data valid; arrives at least 1 cycle after gnt.
imem_rdata_i  input  32  instruction word.
fetch_valid_o  output  1  instruction/PC outputs are valid.
fetch_instr_o  output  32  buffered instruction.
fetch_pc_o  output  32  PC of the buffered instruction (pc_q).
fetch_pcplus4_o  output  32  pc_q + 4, modulo 2^32.

Behaviour:
- Reset (asynchronous, any state): pc_q=RESET_PC, state=REQ, instr_q=0, fetch_valid_o=0. imem_req_o is 1 in the first cycle after rst_n rises.
- All outputs are registered or decoded from state. fetch_valid_o=(state==HOLD). imem_req_o=(state==REQ).
- REQ: requests pc_q.
  - gnt && !redirect: go to WAIT.
  - gnt && redirect: pc_q<=target, go to DROP (the granted word belongs to the old PC).
  - !gnt && redirect: pc_q<=target, stay in REQ. The address changes next cycle.
- WAIT:
  - rvalid && !redirect: instr_q<=rdata, go to HOLD.
  - rvalid && redirect: pc_q<=target, discard data, go to REQ.
  - !rvalid && redirect: pc_q<=target, go to DROP.
- HOLD: instruction is presented.
  - redirect: pc_q<=target, go to REQ. Redirect has priority over stall; the held instruction is dropped.
  - !stall: pc_q<=pc_q+4, go to REQ (handed off this cycle).
  - stall: stay in HOLD; outputs remain stable.
- DROP: waits for the orphaned response.
  - rvalid: discard it, go to REQ.
  - redirect in DROP: pc_q<=target (latest wins), stay in DROP until rvalid. Simultaneous rvalid+redirect goes to REQ with the new target.
- imem_addr_o is stable while imem_req_o is high, except on a same-cycle redirect without gnt.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD). Minimum latency from gnt to fetch_valid_o is 2 cycles.
- pc_q wraps 0xFFFF_FFFC to 0x0000_0000.
- rvalid in REQ or HOLD is a protocol error. It is ignored, and the bench asserts it never occurs.

Decomposition:
- Shared package (cpu_pkg) holds:
  - fetch state enum {REQ, WAIT, HOLD, DROP}, 2-bit encoding;
  - INSTR_BYTES=4;
  - NOP_INSTR=32'h0.
- One sub-module is natural: pc_next_sel. It is combinational and chooses redirect target / pc+4 / hold with the priority redirect > advance > hold, and forces target[1:0]=0.

Test Plan:
- Reset with RESET_PC=0x100; gnt immediate, rvalid 1 cycle later with 0x2002_0001, stall=0 -> addr 0x100, fetch_valid pulses for 1 cycle with instr 0x20020001, pc 0x100, pcplus4 0x104; next request is at 0x104.
- stall_i held high 4 cycles in HOLD -> fetch_valid stays 1 and outputs stay constant; no imem_req. On release, the next request is at pc+4.
- Redirect to 0x0000_2003 while in WAIT, rvalid 3 cycles later -> DROP; the stale word is never presented; the next request address is 0x2000.
- Redirect in the same cycle as gnt in REQ -> DROP; the following rvalid is discarded; the request is reissued at the target.
- Redirect and stall together in HOLD -> fetch_valid falls next cycle; the request goes to the redirect target.
- pc_q=0xFFFF_FFFC is delivered with no stall -> pcplus4 is 0x0000_0000 and the next request address is 0x0; assert reset mid-WAIT -> next cycle REQ at RESET_PC and fetch_valid=0.
